// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two requesters, one op in flight at a time.
// Latency: accept at T, result on rsp_data_o with a one-cycle rsp_valid_o pulse at T+LAT+1 (LAT = LAT_ARITH or LAT_LOGIC).
// Backpressure: req_ready_o is high only in IDLE for the granted requester; responses cannot be stalled.
//
// Ports:
//   clock_i, reset_i          - clock, asynchronous active-high reset
//   req_valid_i / req_ready_o - per-requester handshake, bit i = requester i
//   req_left_i, req_right_i   - {req1[31:0], req0[31:0]} operands
//   req_func_i                - {req1[3:0], req0[3:0]} function codes (func[3]=1 selects a logic op)
//   rsp_valid_o, rsp_data_o   - one-hot response pulse and held result
//   alu_left_o, alu_right_o, alu_func_o, alu_out_i - connection to the external ALU
//   busy_o                    - high while an operation is in flight
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins),
// otherwise arbitration is round-robin. LAT_ARITH / LAT_LOGIC must lie in 1..15.
module alu_arbiter #(
    parameter int LAT_ARITH = 2,
    parameter int LAT_LOGIC = 1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [1:0]  req_valid_i,
    output logic [1:0]  req_ready_o,
    input  logic [63:0] req_left_i,
    input  logic [63:0] req_right_i,
    input  logic [7:0]  req_func_i,
    output logic [1:0]  rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic [31:0] alu_left_o,
    output logic [31:0] alu_right_o,
    output logic [3:0]  alu_func_o,
    input  logic [31:0] alu_out_i,
    output logic        busy_o
);

    localparam logic [3:0] LAT_A = 4'(LAT_ARITH);
    localparam logic [3:0] LAT_L = 4'(LAT_LOGIC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] left_q;
    logic [31:0] right_q;
    logic [3:0]  func_q;
    logic [31:0] rsp_data_q;
    logic [1:0]  rsp_valid_q;
    logic        busy_q;
    logic        gnt_q;          // requester owning the in-flight op
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic        last_q;         // requester granted most recently
`endif

    logic        gnt_sel_d;
    logic        accept_d;
    logic [31:0] left_d;
    logic [31:0] right_d;
    logic [3:0]  func_d;
    logic [3:0]  lat_d;

    // Grant selection and operand mux for the cycle of acceptance.
    always_comb begin
        gnt_sel_d = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt_sel_d = ~req_valid_i[0];
`else
        if (&req_valid_i) begin
            gnt_sel_d = ~last_q;
        end else begin
            gnt_sel_d = req_valid_i[1];
        end
`endif
        // Reset gates the combinational ready so nothing looks accepted while held in reset.
        accept_d = (state_q == IDLE) && (|req_valid_i) && !reset_i;

        req_ready_o = 2'b00;
        if (accept_d) begin
            req_ready_o = gnt_sel_d ? 2'b10 : 2'b01;
        end

        left_d  = gnt_sel_d ? req_left_i[63:32]  : req_left_i[31:0];
        right_d = gnt_sel_d ? req_right_i[63:32] : req_right_i[31:0];
        func_d  = gnt_sel_d ? req_func_i[7:4]    : req_func_i[3:0];
        lat_d   = func_d[3] ? LAT_L : LAT_A;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            left_q      <= 32'd0;
            right_q     <= 32'd0;
            func_q      <= 4'd0;
            rsp_data_q  <= 32'd0;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
            gnt_q       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q      <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        left_q  <= left_d;
                        right_q <= right_d;
                        func_q  <= func_d;
                        cnt_q   <= lat_d;
                        gnt_q   <= gnt_sel_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_q  <= gnt_sel_d;
`endif
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    // Last EXEC cycle: the ALU output is valid now and only now.
                    if (cnt_q <= 4'd1) begin
                        rsp_data_q  <= alu_out_i;
                        rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                        cnt_q       <= 4'd0;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    rsp_valid_q <= 2'b00;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign alu_left_o  = left_q;
    assign alu_right_o = right_q;
    assign alu_func_o  = func_q;
    assign busy_o      = busy_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter LAT_ARITH, default 2, cycles the ALU needs for arithmetic ops (func[3]=0); legal range 1..15.
REQ-002 Parameter LAT_LOGIC, default 1, cycles the ALU needs for logic ops (func[3]=1); legal range 1..15.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  bit i: requester i presents an operation.
REQ-006 req_ready  output  2  bit i: operation of requester i accepted this cycle.
REQ-007 req_left  input  64  left operands, {req1[31:0], req0[31:0]}.
REQ-008 req_right  input  64  right operands, {req1[31:0], req0[31:0]}.
REQ-009 req_func  input  8  ALU function codes, {req1[3:0], req0[3:0]}.
REQ-010 rsp_valid  output  2  bit i: rsp_data holds requester i's result this cycle.
REQ-011 rsp_data  output  32  result of the last completed operation.
REQ-012 alu_left  output  32  to ALU leftIn.
REQ-013 alu_right  output  32  to ALU rightIn.
REQ-014 alu_func  output  4  to ALU func.
REQ-015 alu_out  input  32  from ALU out.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement FSM states IDLE, EXEC and RESP.
REQ-018 In IDLE with any req_valid bit set, the block SHALL grant exactly one requester, drive req_ready[g]=1 combinationally that cycle, latch that requester's left/right/func into internal registers and go to EXEC.
REQ-019 req_ready SHALL be 2'b00 in EXEC and RESP and in IDLE with req_valid=2'b00.
REQ-020 Arbitration SHALL be round-robin: with both bits of req_valid set, grant the requester not granted last; with one bit set, grant that requester.
REQ-021 alu_left, alu_right and alu_func SHALL be driven from the latched registers and SHALL stay stable from the cycle after acceptance until the next acceptance.
REQ-022 On entering EXEC, a 4-bit counter SHALL load LAT_ARITH if latched func[3]=0, else LAT_LOGIC.
REQ-023 The counter SHALL decrement once per EXEC cycle; alu_out SHALL be captured into rsp_data at the edge ending the last EXEC cycle; the FSM SHALL then go to RESP.
REQ-024 Timing: accept in cycle T; EXEC spans T+1..T+LAT; rsp_valid[g]=1 for exactly one cycle, T+LAT+1 (RESP); the earliest next acceptance is T+LAT+2.
REQ-025 RESP SHALL return to IDLE unconditionally; there is no response backpressure.
REQ-026 rsp_data SHALL hold its value until the next capture; rsp_valid SHALL be 2'b00 outside RESP.
REQ-027 Changes on req_* while busy SHALL NOT affect the in-flight operation.
REQ-028 alu_out SHALL be ignored in every cycle except the capture cycle.

Reset
REQ-029 While reset is high, the block SHALL force IDLE and all of the following to zero: req_ready, rsp_valid, rsp_data, alu_left, alu_right, alu_func, busy and the counter.
REQ-030 Reset SHALL set the last-granted pointer to 1, so requester 0 wins the first contention.
REQ-031 Reset asserted during EXEC or RESP SHALL abort the operation with no rsp_valid pulse.

Configuration
REQ-032 With macro ALU_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority: requester 0 always wins contention and the last-granted pointer is not implemented.
REQ-033 Without ALU_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin as specified in REQ-020.

Verification (bench ALU stub: out=left+right after LAT_ARITH cycles if func[3]=0; out=left^right after LAT_LOGIC cycles if func[3]=1)
REQ-034 Reset, then req0 func=4'h0, left=5, right=7 accepted at T -> rsp_valid=2'b01 at T+3, rsp_data=12.
REQ-035 req1 func=4'h8, left=32'hF0F0F0F0, right=32'hFFFF0000 accepted at T -> rsp_valid=2'b10 at T+2, rsp_data=32'h0F0FF0F0.
REQ-036 Both req_valid held high for 4 operations -> grants 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> grants 0,0,0,0.
REQ-037 req0 changes operands and req1 raises req_valid during EXEC -> req_ready=2'b00 until IDLE; result reflects the original operands.
REQ-038 Reset pulsed in the second EXEC cycle -> no rsp_valid pulse, all outputs 0; after reset, simultaneous requests grant requester 0 first.
